// File: rtl/sync_down_counter_pkg.sv
// Shared types for the synchronous loadable down-counter.
package sync_down_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer: accepts a start value over a valid/ready
// handshake, counts down while enabled and pulses done at terminal count.
// With AUTO_RELOAD set, the loaded value is restored at terminal count and
// the counter keeps running.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_load_ready,
    input  logic             i_en,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;

    // FSM and count datapath; done is a registered single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_valid) begin
                        r_count  <= i_load_value;
                        r_reload <= i_load_value;
                        // A zero load is an immediate terminal count.
                        if (i_load_value != '0) begin
                            r_state <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a terminal event in the same cycle.
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else if (i_en) begin
                        if (r_count > ONE) begin
                            r_count <= r_count - ONE;
                        end else begin
                            // count is never 0 in RUN, so this is count == 1.
                            r_done <= 1'b1;
                            if (AUTO_RELOAD) begin
                                r_count <= r_reload;
                            end else begin
                                r_count <= '0;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_load_ready = (r_state == IDLE);
    assign o_busy       = (r_state == RUN);
    assign o_count      = r_count;
    assign o_done       = r_done;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: one non-reload and one auto-reload
// instance, with expected outputs queued per edge and checked after it.
module tb_sync_down_counter;

    logic       clk = 1'b0;
    logic       reset;

    logic       lv0, en0, ab0;
    logic [3:0] val0;
    logic       rdy0, busy0, done0;
    logic [3:0] cnt0;

    logic       lv1, en1, ab1;
    logic [3:0] val1;
    logic       rdy1, busy1, done1;
    logic [3:0] cnt1;

    typedef struct {
        int unsigned dut;
        logic [3:0]  count;
        logic        busy;
        logic        done;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_load_valid (lv0),
        .i_load_value (val0),
        .o_load_ready (rdy0),
        .i_en         (en0),
        .i_abort      (ab0),
        .o_count      (cnt0),
        .o_busy       (busy0),
        .o_done       (done0)
    );

    sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_load_valid (lv1),
        .i_load_value (val1),
        .o_load_ready (rdy1),
        .i_en         (en1),
        .i_abort      (ab1),
        .o_count      (cnt1),
        .o_busy       (busy1),
        .o_done       (done1)
    );

    task automatic exp0(input logic [3:0] c, input logic b, input logic d, input string tag);
        exp_t e;
        e.dut = 0; e.count = c; e.busy = b; e.done = d; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp1(input logic [3:0] c, input logic b, input logic d, input string tag);
        exp_t e;
        e.dut = 1; e.count = c; e.busy = b; e.done = d; e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one rising edge, then check everything queued for that edge.
    task automatic tick();
        exp_t       e;
        logic [3:0] c;
        logic       b, d, r;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                c = cnt0; b = busy0; d = done0; r = rdy0;
            end else begin
                c = cnt1; b = busy1; d = done1; r = rdy1;
            end
            n_cmp++;
            assert (c === e.count) else begin
                n_err++;
                $error("FAIL %s count: got %0d expected %0d", e.tag, c, e.count);
            end
            n_cmp++;
            assert (b === e.busy) else begin
                n_err++;
                $error("FAIL %s busy: got %b expected %b", e.tag, b, e.busy);
            end
            n_cmp++;
            assert (d === e.done) else begin
                n_err++;
                $error("FAIL %s done: got %b expected %b", e.tag, d, e.done);
            end
            n_cmp++;
            assert (r === !e.busy) else begin
                n_err++;
                $error("FAIL %s load_ready: got %b expected %b", e.tag, r, !e.busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        lv0 = 1'b0; en0 = 1'b0; ab0 = 1'b0; val0 = 4'd0;
        lv1 = 1'b0; en1 = 1'b0; ab1 = 1'b0; val1 = 4'd0;

        // Reset state.
        exp0(4'd0, 1'b0, 1'b0, "reset0");
        exp1(4'd0, 1'b0, 1'b0, "reset1");
        tick();
        reset = 1'b0;

        // 1: load 5 with en held high.
        lv0 = 1'b1; val0 = 4'd5; en0 = 1'b1;
        exp0(4'd5, 1'b1, 1'b0, "t1_load");
        tick();
        lv0 = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            exp0(4'(i), 1'b1, 1'b0, "t1_run");
            tick();
        end
        exp0(4'd0, 1'b0, 1'b1, "t1_term");
        tick();
        exp0(4'd0, 1'b0, 1'b0, "t1_after");
        tick();

        // 2: load 6, en alternates 1,0,1,0...; terminal on the 11th edge.
        lv0 = 1'b1; val0 = 4'd6;
        exp0(4'd6, 1'b1, 1'b0, "t2_load");
        tick();
        lv0 = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            en0 = (j % 2 == 1);
            exp0(4'(6 - (j + 1) / 2), 1'b1, 1'b0, "t2_toggle");
            tick();
        end
        en0 = 1'b1;
        exp0(4'd0, 1'b0, 1'b1, "t2_term");
        tick();
        exp0(4'd0, 1'b0, 1'b0, "t2_after");
        tick();

        // 3: load 9, abort at count 3; then abort at count 1.
        lv0 = 1'b1; val0 = 4'd9;
        exp0(4'd9, 1'b1, 1'b0, "t3_load");
        tick();
        lv0 = 1'b0;
        for (int i = 8; i >= 3; i--) begin
            exp0(4'(i), 1'b1, 1'b0, "t3_run");
            tick();
        end
        ab0 = 1'b1;
        exp0(4'd3, 1'b0, 1'b0, "t3_abort3");
        tick();
        ab0 = 1'b0;
        exp0(4'd3, 1'b0, 1'b0, "t3_idle_en");
        tick();
        lv0 = 1'b1; val0 = 4'd2;
        exp0(4'd2, 1'b1, 1'b0, "t3_load2");
        tick();
        lv0 = 1'b0;
        exp0(4'd1, 1'b1, 1'b0, "t3_at1");
        tick();
        ab0 = 1'b1;
        exp0(4'd1, 1'b0, 1'b0, "t3_abort1");
        tick();
        ab0 = 1'b0;
        exp0(4'd1, 1'b0, 1'b0, "t3_after");
        tick();

        // 4: load 0 is an immediate terminal; load held during a run is deferred.
        lv0 = 1'b1; val0 = 4'd0;
        exp0(4'd0, 1'b0, 1'b1, "t4_zero");
        tick();
        lv0 = 1'b0;
        exp0(4'd0, 1'b0, 1'b0, "t4_zero_after");
        tick();
        lv0 = 1'b1; val0 = 4'd4;
        exp0(4'd4, 1'b1, 1'b0, "t4_load4");
        tick();
        val0 = 4'd9;
        for (int i = 3; i >= 1; i--) begin
            exp0(4'(i), 1'b1, 1'b0, "t4_held");
            tick();
        end
        exp0(4'd0, 1'b0, 1'b1, "t4_term");
        tick();
        exp0(4'd9, 1'b1, 1'b0, "t4_accept");
        tick();
        lv0 = 1'b0; ab0 = 1'b1;
        exp0(4'd9, 1'b0, 1'b0, "t4_abort");
        tick();
        ab0 = 1'b0;

        // 5: auto-reload instance, load 3.
        lv1 = 1'b1; val1 = 4'd3; en1 = 1'b1;
        exp1(4'd3, 1'b1, 1'b0, "t5_load");
        tick();
        lv1 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            exp1(4'd2, 1'b1, 1'b0, "t5_c2");
            tick();
            exp1(4'd1, 1'b1, 1'b0, "t5_c1");
            tick();
            exp1(4'd3, 1'b1, 1'b1, "t5_reload");
            tick();
        end
        ab1 = 1'b1;
        exp1(4'd3, 1'b0, 1'b0, "t5_abort");
        tick();
        ab1 = 1'b0;
        lv1 = 1'b1; val1 = 4'd1;
        exp1(4'd1, 1'b1, 1'b0, "t5_load1");
        tick();
        lv1 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            exp1(4'd1, 1'b1, 1'b1, "t5_done_hi");
            tick();
        end
        en1 = 1'b0;
        exp1(4'd1, 1'b1, 1'b0, "t5_en_off");
        tick();
        ab1 = 1'b1;
        exp1(4'd1, 1'b0, 1'b0, "t5_abort1");
        tick();
        ab1 = 1'b0;

        // 6: reset mid-run at count 7 with a load pending.
        lv0 = 1'b1; val0 = 4'd10; en0 = 1'b1;
        exp0(4'd10, 1'b1, 1'b0, "t6_load10");
        tick();
        lv0 = 1'b0;
        for (int i = 9; i >= 7; i--) begin
            exp0(4'(i), 1'b1, 1'b0, "t6_run");
            tick();
        end
        reset = 1'b1; lv0 = 1'b1; val0 = 4'd15;
        exp0(4'd0, 1'b0, 1'b0, "t6_reset");
        tick();
        reset = 1'b0;
        exp0(4'd15, 1'b1, 1'b0, "t6_load15");
        tick();
        lv0 = 1'b0;
        for (int i = 14; i >= 1; i--) begin
            exp0(4'(i), 1'b1, 1'b0, "t6_run15");
            tick();
        end
        exp0(4'd0, 1'b0, 1'b1, "t6_term");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous loadable down-counter/timer for the counter library.
- Counts down from a value accepted over a valid/ready load handshake and pulses `done` when the count reaches zero.
- With AUTO_RELOAD=1, reloads the stored value at terminal count and keeps running.
- Companion to the ripple up-counter blocks: same count domain, opposite direction, fully synchronous.

Parameters:
- WIDTH, 4: width of count and load_value.
- AUTO_RELOAD, 0: 1 = reload the stored value at terminal count and stay running; 0 = stop at zero.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  load request.
- load_value  input  WIDTH  start value; sampled on handshake.
- load_ready  output  1  block can accept a load.
- en  input  1  count enable; decrement occurs only when en=1.
- abort  input  1  stop the current run.
- count  output  WIDTH  current counter value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle terminal-count pulse.

Behaviour:
- Reset (synchronous, active-high) on the edge where reset=1:
  - state=IDLE, count=0, reload register=0, busy=0, done=0, load_ready=1.
  - Reset overrides every other input, including mid-run and mid-handshake.
- States are IDLE and RUN.
  - busy = (state==RUN).
  - load_ready = (state==IDLE); combinational from state.
- Load handshake: accepted on an edge where load_valid && load_ready.
  - count <= load_value and reload register <= load_value.
  - If load_value != 0, state <= RUN.
  - If load_value == 0, stay IDLE and assert done for the following cycle (immediate terminal).
  - load_valid while busy is ignored and not queued. The requester holds it until load_ready.
- RUN, each edge:
  - abort=1: state <= IDLE, count holds, done=0. Abort beats a terminal event in the same cycle.
  - else en=0: count holds.
  - else en=1 and count > 1: count <= count-1.
  - else en=1 and count == 1 (terminal): done <= 1 for exactly one cycle.
    - AUTO_RELOAD=0: count <= 0, state <= IDLE.
    - AUTO_RELOAD=1: count <= reload register, state stays RUN. Count never shows 0.
- Latency: load accepted at edge k with value N and en held high gives count=N after edge k and done=1 after edge k+N.
  - In non-reload mode, load_ready returns high in that same cycle.
  - A new load can be accepted on edge k+N+1, so back-to-back runs have 1 idle cycle.
- done is registered and deasserts on the next edge unless a new terminal event occurs.
  - In AUTO_RELOAD mode with N=1, done stays high every cycle that en=1.
- Width: plain unsigned WIDTH-bit arithmetic. Max load is 2^WIDTH-1. The decrement never underflows, because 0 is never decremented in RUN.
- en and abort are ignored in IDLE.

Decomposition:
- Package sync_down_counter_pkg: typedef enum logic {IDLE, RUN} state_t.
- Single module; no sub-module needed.
- The FSM and the counter datapath live in one sequential process, with load_ready and busy as continuous assignments.

Test Plan (WIDTH=4):
1. Reset, then load 5 with en=1 continuously:
   - count 5,4,3,2,1,0 on successive edges.
   - done high exactly one cycle, coincident with count=0.
   - busy low and load_ready high from that cycle.
2. Load 6, en toggles 1,0,1,0…:
   - count decrements only on en=1 edges.
   - done arrives 11 edges after load; count held during en=0.
3. Load 9, en=1, abort asserted when count=3:
   - next edge: IDLE, count stays 3, no done pulse.
   - Repeat with abort at count=1: still no done.
4. Load 0:
   - count=0, done pulses the next cycle, busy never asserts.
   - load_valid held during a run of 4: ignored until load_ready=1, then accepted on that edge.
5. AUTO_RELOAD=1, load 3, en=1:
   - count 3,2,1,3,2,1…; done pulses every third cycle, busy stays 1.
   - Abort stops it.
   - Load 1 gives done continuously high.
6. Assert reset at count=7 mid-run with load_valid=1 and load_value 15:
   - next edge: count=0, busy=0, done=0, load_ready=1.
   - Load not accepted that edge; load 15 then gives done after 15 edges.
